// File: rtl/fft_pkg.sv
// Shared constants, types and helpers for the 16-point FFT datapath.
// The bitrev helper is also used by the FFT core for its output ordering.
package fft_pkg;

  localparam int N    = 16;
  localparam int W    = 32;
  localparam int IDXW = 4;

  typedef logic signed [W-1:0] sample_t;
  typedef logic [N*W-1:0]      frame_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  function automatic logic [IDXW-1:0] bitrev(input logic [IDXW-1:0] v);
    logic [IDXW-1:0] r;
    r = {IDXW{1'b0}};
    for (int i = 0; i < IDXW; i++) begin
      r[i] = v[IDXW-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_slot_buf.sv
// Two-slot frame store: whole-frame parallel write, single complex sample
// combinational read.
module fft_frame_slot_buf
  import fft_pkg::*;
(
  input  logic             clk,
  input  logic             wr_en,
  input  logic             wr_slot,
  input  logic [N*W-1:0]   wr_re,
  input  logic [N*W-1:0]   wr_im,
  input  logic             rd_slot,
  input  logic [IDXW-1:0]  rd_elem,
  output logic [W-1:0]     rd_re,
  output logic [W-1:0]     rd_im
);

  logic [W-1:0] re_r [2][N];
  logic [W-1:0] im_r [2][N];

  // slot capture; contents are qualified by the occupancy state, so no reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int e = 0; e < N; e++) begin
        re_r[wr_slot][e] <= wr_re[W*e +: W];
        im_r[wr_slot][e] <= wr_im[W*e +: W];
      end
    end
  end

  // element read mux
  always_comb begin
    rd_re = re_r[rd_slot][rd_elem];
    rd_im = im_r[rd_slot][rd_elem];
  end

endmodule

// File: rtl/fft_frame_serializer.sv
// Converts parallel FFT result frames into a one-sample-per-cycle stream,
// double-buffering so the next frame can land while the current one drains.
module fft_frame_serializer
  import fft_pkg::*;
#(
  parameter int BITREV = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frm_valid,
  output logic             frm_ready,
  input  logic [N*W-1:0]   frm_re,
  input  logic [N*W-1:0]   frm_im,
  output logic             s_valid,
  input  logic             s_ready,
  output logic [W-1:0]     s_re,
  output logic [W-1:0]     s_im,
  output logic [IDXW-1:0]  s_idx,
  output logic             s_last,
  output logic [15:0]      frames_done
);

  state_t          state_r;
  state_t          next_state_s;
  logic            wr_ptr_r;
  logic            rd_ptr_r;
  logic [IDXW-1:0] pos_r;
  logic [15:0]     frames_done_r;
  logic            frm_ready_s;
  logic            s_valid_s;
  logic            s_last_s;
  logic            acc_s;
  logic            xfer_s;
  logic            done_s;
  logic [IDXW-1:0] elem_s;

  assign s_last_s = (pos_r == IDXW'(N-1));
  assign acc_s    = frm_valid & frm_ready_s;
  assign xfer_s   = s_valid_s & s_ready;
  assign done_s   = xfer_s & s_last_s;

  // occupancy state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= next_state_s;
    end
  end

  // occupancy next state; accept and completion together leave it unchanged
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (acc_s) next_state_s = ST_ONE;
        else       next_state_s = ST_EMPTY;
      end
      ST_ONE: begin
        if (acc_s && !done_s)      next_state_s = ST_FULL;
        else if (done_s && !acc_s) next_state_s = ST_EMPTY;
        else                       next_state_s = ST_ONE;
      end
      ST_FULL: begin
        if (done_s) next_state_s = ST_ONE;
        else        next_state_s = ST_FULL;
      end
      default: next_state_s = ST_EMPTY;
    endcase
  end

  // handshake decode from registered state only
  always_comb begin
    frm_ready_s = 1'b1;
    s_valid_s   = 1'b0;
    case (state_r)
      ST_EMPTY: begin frm_ready_s = 1'b1; s_valid_s = 1'b0; end
      ST_ONE:   begin frm_ready_s = 1'b1; s_valid_s = 1'b1; end
      ST_FULL:  begin frm_ready_s = 1'b0; s_valid_s = 1'b1; end
      default:  begin frm_ready_s = 1'b1; s_valid_s = 1'b0; end
    endcase
  end

  // slot pointers, stream position and completed-frame counter
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r      <= 1'b0;
      rd_ptr_r      <= 1'b0;
      pos_r         <= {IDXW{1'b0}};
      frames_done_r <= 16'd0;
    end else begin
      if (acc_s) wr_ptr_r <= ~wr_ptr_r;
      else       wr_ptr_r <= wr_ptr_r;
      if (done_s) begin
        pos_r         <= {IDXW{1'b0}};
        rd_ptr_r      <= ~rd_ptr_r;
        frames_done_r <= frames_done_r + 16'd1;
      end else if (xfer_s) begin
        pos_r <= pos_r + IDXW'(1);
      end else begin
        pos_r <= pos_r;
      end
    end
  end

  // element selection within the read slot
  always_comb begin
    if (BITREV != 0) elem_s = bitrev(pos_r);
    else             elem_s = pos_r;
  end

  fft_frame_slot_buf u_buf (
    .clk     (clk),
    .wr_en   (acc_s & ~rst),
    .wr_slot (wr_ptr_r),
    .wr_re   (frm_re),
    .wr_im   (frm_im),
    .rd_slot (rd_ptr_r),
    .rd_elem (elem_s),
    .rd_re   (s_re),
    .rd_im   (s_im)
  );

  assign frm_ready   = frm_ready_s;
  assign s_valid     = s_valid_s;
  assign s_idx       = pos_r;
  assign s_last      = s_last_s;
  assign frames_done = frames_done_r;

endmodule
